if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 26 ++
 rtl/if_btb.sv | 71 +++++++
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage and its neighbours: bus widths,
// the default boot address, the fetch-stage state type and a bus packer.
package if_stage_pkg;

    localparam int unsigned IF_TO_IPD_BUS_WD = 96;
    localparam int unsigned ID_TO_IPD_BUS_WD = 33;
    // Redirects from ID use the same {cancel, pc} encoding as the IPD bus.
    localparam int unsigned ID_TO_IF_BUS_WD  = ID_TO_IPD_BUS_WD;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c000000;

    typedef enum logic {
        StBoot,
        StRun
    } fs_state_e;

    // Layout seen by pre-decode: {pred_PC, inst_PC, instruction slot}.
    // The instruction slot is zero; pre-decode takes the word from the RAM.
    function automatic logic [IF_TO_IPD_BUS_WD-1:0] pack_if_bus(
        input logic [31:0] pred_pc,
        input logic [31:0] inst_pc
    );
        return {pred_pc, inst_pc, 32'b0};
    endfunction

endpackage

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer for the fetch stage.
// Combinational lookup on the current fetch PC; synchronous update from ID.
// A same-cycle update and lookup of one index returns the old contents.
module if_btb
    import if_stage_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] hit_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken
);

    localparam int unsigned IdxW = $clog2(BTB_ENTRIES);
    localparam int unsigned TagW = 30 - IdxW;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TagW-1:0]        tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];

    logic [IdxW-1:0] lk_idx;
    logic [TagW-1:0] lk_tag;
    logic [IdxW-1:0] up_idx;
    logic [TagW-1:0] up_tag;
    logic            up_tag_match;

    assign lk_idx = lookup_pc[2 +: IdxW];
    assign lk_tag = lookup_pc[31 -: TagW];
    assign up_idx = upd_pc[2 +: IdxW];
    assign up_tag = upd_pc[31 -: TagW];

    // Instructions are word aligned; the byte offset never reaches the BTB.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup: hit when the indexed entry is live and its tag matches.
    always_comb begin
        hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        hit_target = target_q[lk_idx];
    end

    assign up_tag_match = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Valid bits: taken allocates, not-taken evicts only its own entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
            end else if (up_tag_match) begin
                valid_q[up_idx] <= 1'b0;
            end
        end
    end

    // Tag/target payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the synchronous
// instruction RAM and hands {pred_PC, inst_PC} to pre-decode.
// Optional branch target buffer enabled by defining IF_BTB_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned BTB_ENTRIES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ID_TO_IF_BUS_WD-1:0]  ID_to_IF_bus,
    input  logic                        br_upd_valid,
    input  logic [31:0]                 br_upd_pc,
    input  logic [31:0]                 br_upd_target,
    input  logic                        br_upd_taken,
    input  logic                        IPD_allow_in,
    output logic                        IF_to_IPD_valid,
    output logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
    output logic                        inst_ram_en,
    output logic [3:0]                  inst_ram_we,
    output logic [31:0]                 inst_ram_addr,
    output logic [31:0]                 inst_ram_w_data
);

    fs_state_e   state_q, state_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic [31:0] pred_pc;
    logic [31:0] seq_pc;
    logic        br_taken_cancel;
    logic [31:0] pc_from_id;
    logic        xfer;

    assign br_taken_cancel = ID_to_IF_bus[32];
    assign pc_from_id      = ID_to_IF_bus[31:0];

    // Sequential successor; wraps silently at the top of the address space.
    assign seq_pc = fs_pc_q + 32'd4;

`ifdef IF_BTB_EN
    logic        btb_hit;
    logic [31:0] btb_target;

    if_btb #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .reset      (reset),
        .lookup_pc  (fs_pc_q),
        .hit        (btb_hit),
        .hit_target (btb_target),
        .upd_valid  (br_upd_valid),
        .upd_pc     (br_upd_pc),
        .upd_target (br_upd_target),
        .upd_taken  (br_upd_taken)
    );

    assign pred_pc = btb_hit ? btb_target : seq_pc;
`else
    // Without a BTB the resolved-branch feed has no consumer.
    localparam int unsigned unused_btb_entries = BTB_ENTRIES;
    logic unused_br_upd;
    assign unused_br_upd = ^{br_upd_valid, br_upd_pc, br_upd_target, br_upd_taken};

    assign pred_pc = seq_pc;
`endif

    // Fetch state register: BOOT holds off the first fetch for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, valid and handshake; a redirect squashes the current fetch.
    always_comb begin
        state_d         = state_q;
        IF_to_IPD_valid = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                IF_to_IPD_valid = !br_taken_cancel;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
        xfer = IF_to_IPD_valid && IPD_allow_in;
    end

    // Fetch PC priority: redirect beats handshake beats hold.
    always_comb begin
        fs_pc_d = fs_pc_q;
        if (br_taken_cancel) begin
            fs_pc_d = pc_from_id;
        end else if (xfer) begin
            fs_pc_d = pred_pc;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_pc_q <= RESET_PC;
        end else begin
            fs_pc_q <= fs_pc_d;
        end
    end

    // RAM is read only on a handshake so its output holds across a stall;
    // pre-decode latches inst_PC on the same edge the RAM samples the address.
    always_comb begin
        inst_ram_en     = xfer;
        inst_ram_we     = 4'b0;
        inst_ram_addr   = fs_pc_q;
        inst_ram_w_data = 32'b0;
        IF_to_IPD_bus   = pack_if_bus(pred_pc, fs_pc_q);
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a scoreboard of expected fetches
// ({inst_PC, pred_PC}) is consumed on every valid handshake, plus direct
// checks of reset, stall and redirect cycles.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RPC = 32'h1c000000;

    logic        clk;
    logic        reset;
    logic [32:0] ID_to_IF_bus;
    logic        br_upd_valid;
    logic [31:0] br_upd_pc;
    logic [31:0] br_upd_target;
    logic        br_upd_taken;
    logic        IPD_allow_in;
    logic        IF_to_IPD_valid;
    logic [95:0] IF_to_IPD_bus;
    logic        inst_ram_en;
    logic [3:0]  inst_ram_we;
    logic [31:0] inst_ram_addr;
    logic [31:0] inst_ram_w_data;

    if_stage #(
        .RESET_PC    (RPC),
        .BTB_ENTRIES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_to_IF_bus    (ID_to_IF_bus),
        .br_upd_valid    (br_upd_valid),
        .br_upd_pc       (br_upd_pc),
        .br_upd_target   (br_upd_target),
        .br_upd_taken    (br_upd_taken),
        .IPD_allow_in    (IPD_allow_in),
        .IF_to_IPD_valid (IF_to_IPD_valid),
        .IF_to_IPD_bus   (IF_to_IPD_bus),
        .inst_ram_en     (inst_ram_en),
        .inst_ram_we     (inst_ram_we),
        .inst_ram_addr   (inst_ram_addr),
        .inst_ram_w_data (inst_ram_w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pred;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pred);
        exp_t e;
        e.inst = inst;
        e.pred = pred;
        sb_q.push_back(e);
    endtask

    // At the negedge: consume one scoreboard entry per handshake.
    task automatic at_neg();
        exp_t e;
        @(negedge clk);
        if (IF_to_IPD_valid && IPD_allow_in) begin
            check("sb_nonempty", 96'(sb_q.size() != 0), 96'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("fetch_bus", IF_to_IPD_bus, {e.pred, e.inst, 32'b0});
                check("fetch_addr", 96'(inst_ram_addr), 96'(e.inst));
                check("fetch_en", 96'(inst_ram_en), 96'd1);
            end
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        at_neg();
        to_pos();
    endtask

    task automatic set_cancel(input logic c, input logic [31:0] pc);
        ID_to_IF_bus = {c, pc};
    endtask

    initial begin
        reset         = 1'b1;
        ID_to_IF_bus  = '0;
        br_upd_valid  = 1'b0;
        br_upd_pc     = '0;
        br_upd_target = '0;
        br_upd_taken  = 1'b0;
        IPD_allow_in  = 1'b1;

        // Values while reset is held.
        to_pos();
        to_pos();
        at_neg();
        check("rst_valid", 96'(IF_to_IPD_valid), 96'd0);
        check("rst_en", 96'(inst_ram_en), 96'd0);
        check("rst_addr", 96'(inst_ram_addr), 96'(RPC));
        check("rst_bus", IF_to_IPD_bus, {RPC + 32'd4, RPC, 32'b0});
        check("rst_we", 96'({inst_ram_we, inst_ram_w_data}), 96'd0);
        to_pos();

        // Release: one BOOT bubble, then sequential fetch.
        reset = 1'b0;
        at_neg();
        check("boot_valid", 96'(IF_to_IPD_valid), 96'd0);
        to_pos();
        push(32'h1c000000, 32'h1c000004);
        push(32'h1c000004, 32'h1c000008);
        cycle();
        cycle();

        // Three-cycle stall at 0x1c000008.
        IPD_allow_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("stall_valid", 96'(IF_to_IPD_valid), 96'd1);
            check("stall_en", 96'(inst_ram_en), 96'd0);
            check("stall_bus", IF_to_IPD_bus, {32'h1c00000c, 32'h1c000008, 32'b0});
            to_pos();
        end
        IPD_allow_in = 1'b1;
        push(32'h1c000008, 32'h1c00000c);
        push(32'h1c00000c, 32'h1c000010);
        cycle();
        cycle();

        // Redirect arriving during a stall.
        IPD_allow_in = 1'b0;
        cycle();
        set_cancel(1'b1, 32'h1c000100);
        at_neg();
        check("cancel_valid", 96'(IF_to_IPD_valid), 96'd0);
        check("cancel_en", 96'(inst_ram_en), 96'd0);
        to_pos();
        set_cancel(1'b0, 32'h0);
        IPD_allow_in = 1'b1;
        push(32'h1c000100, 32'h1c000104);
        cycle();

        // Back-to-back redirects: only the latest target is fetched.
        set_cancel(1'b1, 32'h1c000200);
        at_neg();
        check("cancel2a_valid", 96'(IF_to_IPD_valid), 96'd0);
        to_pos();
        set_cancel(1'b1, 32'h1c000300);
        at_neg();
        check("cancel2b_valid", 96'(IF_to_IPD_valid), 96'd0);
        check("cancel2b_en", 96'(inst_ram_en), 96'd0);
        to_pos();
        set_cancel(1'b0, 32'h0);
        push(32'h1c000300, 32'h1c000304);
        cycle();

        // Wrap at the top of the address space.
        set_cancel(1'b1, 32'hfffffffc);
        cycle();
        set_cancel(1'b0, 32'h0);
        push(32'hfffffffc, 32'h00000000);
        push(32'h00000000, 32'h00000004);
        cycle();
        cycle();

        // Taken update for 0x1c000010, then fetch it.
        set_cancel(1'b1, 32'h1c000010);
        br_upd_valid  = 1'b1;
        br_upd_pc     = 32'h1c000010;
        br_upd_target = 32'h1c000080;
        br_upd_taken  = 1'b1;
        cycle();
        set_cancel(1'b0, 32'h0);
        br_upd_valid = 1'b0;
`ifdef IF_BTB_EN
        push(32'h1c000010, 32'h1c000080);
`else
        push(32'h1c000010, 32'h1c000014);
`endif
        cycle();

        // Not-taken update of the same pc evicts the entry.
        set_cancel(1'b1, 32'h1c000010);
        br_upd_valid = 1'b1;
        br_upd_taken = 1'b0;
        cycle();
        set_cancel(1'b0, 32'h0);
        br_upd_valid = 1'b0;
        push(32'h1c000010, 32'h1c000014);
        cycle();

        // Reset mid-stream.
        IPD_allow_in = 1'b0;
        reset = 1'b1;
        cycle();
        at_neg();
        check("mrst_valid", 96'(IF_to_IPD_valid), 96'd0);
        check("mrst_addr", 96'(inst_ram_addr), 96'(RPC));
        to_pos();
        reset = 1'b0;
        IPD_allow_in = 1'b1;
        at_neg();
        check("mrst_boot_valid", 96'(IF_to_IPD_valid), 96'd0);
        to_pos();
        push(RPC, RPC + 32'd4);
        cycle();

        check("sb_drained", 96'(sb_q.size()), 96'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
